// File: rtl/stream_rr_arbiter.sv
// Round-robin stream arbiter: NUM valid/ready requesters into one registered output,
// with per-grant bursts of up to MAX_BURST beats and same-cycle hand-over.
module stream_rr_arbiter #(
  parameter int unsigned DWIDTH    = 8,
  parameter int unsigned NUM       = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                    aclk_i,
  input  logic                    areset_i,
  input  logic [NUM-1:0]          valid_i,
  input  logic [NUM*DWIDTH-1:0]   data_i,
  output logic [NUM-1:0]          ready_o,
  output logic                    valid_o,
  output logic [DWIDTH-1:0]       data_o,
  output logic [$clog2(NUM)-1:0]  src_o,
  input  logic                    ready_i
);

  localparam int unsigned SW = $clog2(NUM);
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StHold = 1'b1;

  logic [0:0]        r_state;
  logic [SW-1:0]     r_owner;
  logic [CW-1:0]     r_cnt;
  logic [SW-1:0]     r_last;
  logic              r_valid;
  logic [DWIDTH-1:0] r_data;
  logic [SW-1:0]     r_src;

  logic              w_load_en;
  logic              w_found;
  logic [SW-1:0]     w_cand;
  logic              w_xfer;
  logic [CW-1:0]     w_new_cnt;
  logic [DWIDTH-1:0] w_cand_data;

  function automatic logic [SW-1:0] f_wrap(input logic [SW-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM) sum = sum - NUM;
    return sum[SW-1:0];
  endfunction

  assign w_load_en = ~r_valid | ready_i;

  // The owner keeps the grant while it stays valid; otherwise scan starting just past last,
  // which equals the owner in HOLD, so an early release hands over in the same cycle.
  always_comb begin
    w_found = 1'b0;
    w_cand  = '0;
    if (r_state == StHold && valid_i[r_owner]) begin
      w_found = 1'b1;
      w_cand  = r_owner;
    end else begin
      for (int unsigned i = 1; i <= NUM; i++) begin
        if (!w_found && valid_i[f_wrap(r_last, i)]) begin
          w_found = 1'b1;
          w_cand  = f_wrap(r_last, i);
        end
      end
    end
  end

  always_comb begin
    ready_o = '0;
    if (!areset_i && w_load_en && w_found) ready_o[w_cand] = 1'b1;
  end

  assign w_xfer      = w_load_en & w_found;
  assign w_new_cnt   = (r_state == StHold && w_cand == r_owner) ? r_cnt + CW'(1) : CW'(1);
  assign w_cand_data = data_i[32'(w_cand) * DWIDTH +: DWIDTH];

  always_ff @(posedge aclk_i or posedge areset_i) begin
    if (areset_i) begin
      r_state <= StIdle;
      r_owner <= '0;
      r_cnt   <= '0;
      r_last  <= SW'(NUM - 1);
      r_valid <= 1'b0;
      r_data  <= '0;
      r_src   <= '0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= w_cand_data;
      r_src   <= w_cand;
      r_last  <= w_cand;
      if (w_new_cnt == CW'(MAX_BURST)) begin
        r_state <= StIdle;
        r_cnt   <= '0;
      end else begin
        r_state <= StHold;
        r_owner <= w_cand;
        r_cnt   <= w_new_cnt;
      end
    end else if (w_load_en) begin
      // Output drained with nobody requesting: drop valid, keep data/src and last.
      r_valid <= 1'b0;
      r_state <= StIdle;
      r_cnt   <= '0;
    end
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign src_o   = r_src;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed and randomized checks for stream_rr_arbiter with NUM=4, MAX_BURST=4, DWIDTH=8.
module tb_stream_rr_arbiter;

  logic        aclk = 1'b0;
  logic        areset;
  logic [3:0]  valid;
  logic [31:0] data_in;
  logic [3:0]  ready_o;
  logic        valid_o;
  logic [7:0]  data_o;
  logic [1:0]  src_o;
  logic        ready;

  logic [7:0]  chd [4];
  int          total = 0;
  int          bad   = 0;
  int          rr_exp [17] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0};
  int          er_exp [4]  = '{3, 3, 3, 0};
  int          in_seq [4];
  int          out_seq [4];
  int          wait_cnt [4];

  stream_rr_arbiter #(
    .DWIDTH   (8),
    .NUM      (4),
    .MAX_BURST(4)
  ) dut (
    .aclk_i  (aclk),
    .areset_i(areset),
    .valid_i (valid),
    .data_i  (data_in),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .src_o   (src_o),
    .ready_i (ready)
  );

  always #5 aclk = ~aclk;

  always_comb begin
    data_in = '0;
    for (int k = 0; k < 4; k++) data_in[k*8 +: 8] = chd[k];
  end

  task automatic do_reset();
    areset = 1'b1;
    valid  = 4'b0000;
    ready  = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    valid  = 4'b1111;
    ready  = 1'b1;
    for (int k = 0; k < 4; k++) chd[k] = 8'(8'hA0 + k);
    #1;
    total++; if (ready_o !== 4'b0000) begin bad++; $display("FAIL rst_ready: got %b want 0000", ready_o); end
    @(posedge aclk); #1;
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", valid_o); end
    total++; if (data_o !== 8'h00) begin bad++; $display("FAIL rst_data: got %h want 00", data_o); end
    total++; if (src_o !== 2'd0) begin bad++; $display("FAIL rst_src: got %0d want 0", src_o); end
    // Release with 1010: first grant goes to channel 1 on the very next edge.
    valid  = 4'b1010;
    areset = 1'b0;
    #1;
    total++; if (ready_o !== 4'b0010) begin bad++; $display("FAIL rel_ready: got %b want 0010", ready_o); end
    @(posedge aclk); #1;
    total++; if (valid_o !== 1'b1 || src_o !== 2'd1 || data_o !== 8'hA1) begin
      bad++; $display("FAIL rel_beat: got v=%b src=%0d d=%h want v=1 src=1 d=a1", valid_o, src_o, data_o);
    end
    // Mid-cycle reset while channel 1 owns the burst.
    valid = 4'b1011;
    #2;
    areset = 1'b1;
    #1;
    total++; if (valid_o !== 1'b0 || data_o !== 8'h00 || src_o !== 2'd0) begin
      bad++; $display("FAIL async_rst: got v=%b d=%h src=%0d want 0/00/0", valid_o, data_o, src_o);
    end
    total++; if (ready_o !== 4'b0000) begin bad++; $display("FAIL async_rst_ready: got %b want 0000", ready_o); end
    @(posedge aclk); #1;
    areset = 1'b0;
    #1;
    total++; if (ready_o !== 4'b0001) begin bad++; $display("FAIL rst2_ready: got %b want 0001", ready_o); end
    @(posedge aclk); #1;
    total++; if (valid_o !== 1'b1 || src_o !== 2'd0) begin
      bad++; $display("FAIL rst2_beat: got v=%b src=%0d want v=1 src=0", valid_o, src_o);
    end
    valid = 4'b0000;
  endtask

  task automatic test_round_robin();
    do_reset();
    valid = 4'b1111;
    ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(posedge aclk); #1;
      total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL rr_valid beat %0d: got %b want 1", i, valid_o); end
      total++; if (src_o !== 2'(rr_exp[i]) || data_o !== chd[rr_exp[i]]) begin
        bad++; $display("FAIL rr_src beat %0d: got src=%0d d=%h want src=%0d d=%h", i, src_o, data_o,
                        rr_exp[i], chd[rr_exp[i]]);
      end
    end
    valid = 4'b0000;
  endtask

  task automatic test_single();
    do_reset();
    valid = 4'b0100;
    ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge aclk); #1;
      total++; if (valid_o !== 1'b1 || src_o !== 2'd2) begin
        bad++; $display("FAIL single beat %0d: got v=%b src=%0d want v=1 src=2", i, valid_o, src_o);
      end
    end
    valid = 4'b0000;
    @(posedge aclk); #1;
    total++; if (valid_o !== 1'b0 || src_o !== 2'd2 || data_o !== chd[2]) begin
      bad++; $display("FAIL single_drain: got v=%b src=%0d d=%h want v=0 src=2 d=%h", valid_o, src_o,
                      data_o, chd[2]);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    chd[0] = 8'h55;
    valid  = 4'b0001;
    ready  = 1'b1;
    @(posedge aclk); #1;
    total++; if (valid_o !== 1'b1 || data_o !== 8'h55) begin
      bad++; $display("FAIL bp_first: got v=%b d=%h want v=1 d=55", valid_o, data_o);
    end
    ready  = 1'b0;
    chd[0] = 8'h66;
    #1;
    total++; if (ready_o !== 4'b0000) begin bad++; $display("FAIL bp_ready: got %b want 0000", ready_o); end
    for (int i = 0; i < 3; i++) begin
      @(posedge aclk); #1;
      total++; if (valid_o !== 1'b1 || data_o !== 8'h55 || src_o !== 2'd0 || ready_o !== 4'b0000) begin
        bad++; $display("FAIL bp_hold cyc %0d: got v=%b d=%h src=%0d rdy=%b want 1/55/0/0000", i, valid_o,
                        data_o, src_o, ready_o);
      end
    end
    ready = 1'b1;
    #1;
    total++; if (ready_o !== 4'b0001) begin bad++; $display("FAIL bp_comb_ready: got %b want 0001", ready_o); end
    @(posedge aclk); #1;
    total++; if (valid_o !== 1'b1 || data_o !== 8'h66 || src_o !== 2'd0) begin
      bad++; $display("FAIL bp_reload: got v=%b d=%h src=%0d want v=1 d=66 src=0", valid_o, data_o, src_o);
    end
    valid  = 4'b0000;
    chd[0] = 8'hA0;
  endtask

  task automatic test_early_release();
    do_reset();
    valid = 4'b0001;
    ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge aclk); #1;
      total++; if (src_o !== 2'd0 || valid_o !== 1'b1) begin
        bad++; $display("FAIL er_owner beat %0d: got v=%b src=%0d want v=1 src=0", i, valid_o, src_o);
      end
    end
    valid = 4'b1000;
    #1;
    total++; if (ready_o !== 4'b1000) begin bad++; $display("FAIL er_handover: got %b want 1000", ready_o); end
    @(posedge aclk); #1;
    total++; if (valid_o !== 1'b1 || src_o !== 2'd3) begin
      bad++; $display("FAIL er_first: got v=%b src=%0d want v=1 src=3", valid_o, src_o);
    end
    // Channel 3 started a fresh burst, so it gets three more beats before 0 is served.
    valid = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      @(posedge aclk); #1;
      total++; if (valid_o !== 1'b1 || src_o !== 2'(er_exp[i])) begin
        bad++; $display("FAIL er_burst beat %0d: got v=%b src=%0d want v=1 src=%0d", i, valid_o, src_o,
                        er_exp[i]);
      end
    end
    valid = 4'b0000;
  endtask

  task automatic test_scoreboard();
    logic [3:0] hs;
    logic [7:0] exp_d;
    hs = 4'b0000;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      in_seq[k] = 0; out_seq[k] = 0; wait_cnt[k] = 0;
    end
    for (int cyc = 0; cyc < 10020; cyc++) begin
      for (int k = 0; k < 4; k++) begin
        if (cyc >= 10000) valid[k] = 1'b0;
        else if (hs[k] || !valid[k]) valid[k] = ($urandom_range(1, 0) == 1);
        chd[k] = {2'(k), 6'(in_seq[k])};
      end
      ready = (cyc >= 10000) ? 1'b1 : ($urandom_range(3, 0) != 0);
      @(negedge aclk);
      hs = ready_o & valid;
      total++; if (!$onehot0(ready_o)) begin bad++; $display("FAIL sb_onehot cyc %0d: got %b", cyc, ready_o); end
      total++; if ((|valid) && (!valid_o || ready) && !(|hs)) begin
        bad++; $display("FAIL sb_throughput cyc %0d: got hs=%b want a grant (valid=%b)", cyc, hs, valid);
      end
      if (valid_o && ready) begin
        exp_d = {src_o, 6'(out_seq[src_o])};
        total++; if (data_o !== exp_d) begin
          bad++; $display("FAIL sb_order cyc %0d: got d=%h want %h (src=%0d)", cyc, data_o, exp_d, src_o);
        end
        out_seq[src_o]++;
      end
      for (int k = 0; k < 4; k++) begin
        if (hs[k]) begin
          total++; if (wait_cnt[k] > 12) begin
            bad++; $display("FAIL sb_fair ch %0d: got wait=%0d want <=12", k, wait_cnt[k]);
          end
          wait_cnt[k] = 0;
          in_seq[k]++;
        end else if (!valid[k]) begin
          wait_cnt[k] = 0;
        end else if (|hs) begin
          wait_cnt[k]++;
        end
      end
      @(posedge aclk); #1;
    end
    for (int k = 0; k < 4; k++) begin
      total++; if (out_seq[k] !== in_seq[k]) begin
        bad++; $display("FAIL sb_count ch %0d: got out=%0d want %0d", k, out_seq[k], in_seq[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_backpressure();
    test_early_release();
    test_scoreboard();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
